// File: rtl/reg_bank_8088_pkg.sv
// rtl/reg_bank_8088_pkg.sv - shared types, bank indices and byte-lane helper for the 8088 register access path
package reg_bank_8088_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_OPER   = 3'd2,
    ST_RESULT = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

  localparam logic [2:0] IDX_AX = 3'd0;
  localparam logic [2:0] IDX_BX = 3'd1;
  localparam logic [2:0] IDX_CX = 3'd2;
  localparam logic [2:0] IDX_DX = 3'd3;
  localparam logic [2:0] IDX_SP = 3'd4;
  localparam logic [2:0] IDX_BP = 3'd5;
  localparam logic [2:0] IDX_SI = 3'd6;
  localparam logic [2:0] IDX_DI = 3'd7;

  localparam logic SIZE_8  = 1'b0;
  localparam logic SIZE_16 = 1'b1;

  // Word operands pass through; byte operands take one lane and widen it.
  function automatic logic [15:0] lane_extend(input logic [15:0] d, input logic w,
                                              input logic hl, input logic sext);
    logic [7:0] b;
    b = hl ? d[15:8] : d[7:0];
    if (w) return d;
    return {(sext ? {8{b[7]}} : 8'h00), b};
  endfunction

endpackage

// File: rtl/reg_field_decoder_8088.sv
// rtl/reg_field_decoder_8088.sv - maps an 8088 {w, reg field} to bank index and high/low byte select
module reg_field_decoder_8088
  import reg_bank_8088_pkg::*;
(
  input  logic       i_w,
  input  logic [2:0] i_field,
  output logic [2:0] o_index,
  output logic       o_hl
);

  logic [2:0] w_low_idx;

  always_comb begin
    case (i_field[1:0])
      2'b00:   w_low_idx = IDX_AX;
      2'b01:   w_low_idx = IDX_CX;
      2'b10:   w_low_idx = IDX_DX;
      default: w_low_idx = IDX_BX;
    endcase
    // SP/BP/SI/DI fields already equal their bank index
    o_index = (i_w && i_field[2]) ? i_field : w_low_idx;
    o_hl    = ~i_w & i_field[2];
  end

endmodule

// File: rtl/reg_access_ctrl_8088.sv
// rtl/reg_access_ctrl_8088.sv - read/ALU/write-back sequencer for the 8088 register bank
module reg_access_ctrl_8088
  import reg_bank_8088_pkg::*;
#(
  parameter bit BYTE_SEXT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_w,
  input  logic [2:0]  i_req_dst,
  input  logic [2:0]  i_req_src,
  input  logic        i_req_wb,
  output logic        o_op_valid,
  input  logic        i_op_ready,
  output logic [15:0] o_op_a,
  output logic [15:0] o_op_b,
  input  logic        i_res_valid,
  output logic        o_res_ready,
  input  logic [15:0] i_res_data,
  output logic        o_done,
  output logic        o_bank_en_write,
  output logic [2:0]  o_bank_reg_write,
  output logic [15:0] o_bank_write_data,
  output logic        o_bank_size,
  output logic        o_bank_sel_hl,
  output logic [2:0]  o_bank_reg_read1,
  output logic [2:0]  o_bank_reg_read2,
  input  logic [15:0] i_bank_read_data1,
  input  logic [15:0] i_bank_read_data2
);

  state_t      r_state, w_next;
  logic        r_w, r_wb, r_dst_hl, r_src_hl;
  logic [2:0]  r_dst_idx, r_src_idx;
  logic [15:0] r_op_a, r_op_b, r_write_data;
  logic [2:0]  r_reg_write;
  logic        r_size, r_sel_hl;
  logic [2:0]  w_dst_idx, w_src_idx;
  logic        w_dst_hl, w_src_hl;

  reg_field_decoder_8088 u_dec_dst (
    .i_w     (i_req_w),
    .i_field (i_req_dst),
    .o_index (w_dst_idx),
    .o_hl    (w_dst_hl)
  );

  reg_field_decoder_8088 u_dec_src (
    .i_w     (i_req_w),
    .i_field (i_req_src),
    .o_index (w_src_idx),
    .o_hl    (w_src_hl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_w          <= 1'b0;
      r_wb         <= 1'b0;
      r_dst_hl     <= 1'b0;
      r_src_hl     <= 1'b0;
      r_dst_idx    <= 3'd0;
      r_src_idx    <= 3'd0;
      r_op_a       <= 16'h0000;
      r_op_b       <= 16'h0000;
      r_write_data <= 16'h0000;
      r_reg_write  <= 3'd0;
      r_size       <= 1'b0;
      r_sel_hl     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (i_req_valid) begin
          r_w       <= i_req_w;
          r_wb      <= i_req_wb;
          r_dst_idx <= w_dst_idx;
          r_dst_hl  <= w_dst_hl;
          r_src_idx <= w_src_idx;
          r_src_hl  <= w_src_hl;
        end
        ST_READ: begin
          r_op_a <= lane_extend(i_bank_read_data1, r_w, r_dst_hl, BYTE_SEXT);
          r_op_b <= lane_extend(i_bank_read_data2, r_w, r_src_hl, BYTE_SEXT);
        end
        // Bank write fields are captured here so they hold after WRITE
        ST_RESULT: if (i_res_valid && r_wb) begin
          r_reg_write  <= r_dst_idx;
          r_size       <= r_w ? SIZE_16 : SIZE_8;
          r_sel_hl     <= r_dst_hl & ~r_w;
          r_write_data <= r_w ? i_res_data : {8'h00, i_res_data[7:0]};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next          = r_state;
    o_req_ready     = 1'b0;
    o_op_valid      = 1'b0;
    o_res_ready     = 1'b0;
    o_done          = 1'b0;
    o_bank_en_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = ST_READ;
      end
      ST_READ: w_next = ST_OPER;
      ST_OPER: begin
        o_op_valid = 1'b1;
        if (i_op_ready) w_next = ST_RESULT;
      end
      ST_RESULT: begin
        o_res_ready = 1'b1;
        if (i_res_valid) begin
          w_next = r_wb ? ST_WRITE : ST_IDLE;
          o_done = ~r_wb;
        end
      end
      ST_WRITE: begin
        o_bank_en_write = 1'b1;
        o_done          = 1'b1;
        w_next          = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign o_op_a            = r_op_a;
  assign o_op_b            = r_op_b;
  assign o_bank_reg_read1  = r_dst_idx;
  assign o_bank_reg_read2  = r_src_idx;
  assign o_bank_reg_write  = r_reg_write;
  assign o_bank_write_data = r_write_data;
  assign o_bank_size       = r_size;
  assign o_bank_sel_hl     = r_sel_hl;

endmodule

// File: tb/tb_reg_access_ctrl_8088.sv
// tb/tb_reg_access_ctrl_8088.sv - bench for reg_access_ctrl_8088, zero- and sign-extending instances side by side
module tb_reg_access_ctrl_8088;

  logic        clk, reset;
  logic        req_valid, req_w, req_wb, op_ready, res_valid;
  logic [2:0]  req_dst, req_src;
  logic [15:0] res_data;

  logic        rq_z, ov_z, rr_z, dn_z, en_z, sz_z, hl_z;
  logic        rq_s, ov_s, rr_s, dn_s, en_s, sz_s, hl_s;
  logic [15:0] a_z, b_z, wd_z, rd1_z, rd2_z;
  logic [15:0] a_s, b_s, wd_s, rd1_s, rd2_s;
  logic [2:0]  rw_z, r1_z, r2_z, rw_s, r1_s, r2_s;

  logic [15:0] bank_z [8];
  logic [15:0] bank_s [8];
  logic [15:0] exp_bank [8];
  int          wr_cnt_z, wr_cnt_s;
  logic        pl_en;
  logic [2:0]  pl_idx;
  logic [15:0] pl_val;

  int n_tests, n_fail;

  // Bank order AX BX CX DX SP BP SI DI; tables give index per 8088 reg field
  int WORD_IDX [8];
  int BYTE_IDX [8];

  assign rd1_z = bank_z[r1_z];
  assign rd2_z = bank_z[r2_z];
  assign rd1_s = bank_s[r1_s];
  assign rd2_s = bank_s[r2_s];

  reg_access_ctrl_8088 #(.BYTE_SEXT(1'b0)) u_dut_z (
    .clk(clk), .reset(reset), .i_req_valid(req_valid), .o_req_ready(rq_z),
    .i_req_w(req_w), .i_req_dst(req_dst), .i_req_src(req_src), .i_req_wb(req_wb),
    .o_op_valid(ov_z), .i_op_ready(op_ready), .o_op_a(a_z), .o_op_b(b_z),
    .i_res_valid(res_valid), .o_res_ready(rr_z), .i_res_data(res_data), .o_done(dn_z),
    .o_bank_en_write(en_z), .o_bank_reg_write(rw_z), .o_bank_write_data(wd_z),
    .o_bank_size(sz_z), .o_bank_sel_hl(hl_z), .o_bank_reg_read1(r1_z),
    .o_bank_reg_read2(r2_z), .i_bank_read_data1(rd1_z), .i_bank_read_data2(rd2_z)
  );

  reg_access_ctrl_8088 #(.BYTE_SEXT(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .i_req_valid(req_valid), .o_req_ready(rq_s),
    .i_req_w(req_w), .i_req_dst(req_dst), .i_req_src(req_src), .i_req_wb(req_wb),
    .o_op_valid(ov_s), .i_op_ready(op_ready), .o_op_a(a_s), .o_op_b(b_s),
    .i_res_valid(res_valid), .o_res_ready(rr_s), .i_res_data(res_data), .o_done(dn_s),
    .o_bank_en_write(en_s), .o_bank_reg_write(rw_s), .o_bank_write_data(wd_s),
    .o_bank_size(sz_s), .o_bank_sel_hl(hl_s), .o_bank_reg_read1(r1_s),
    .o_bank_reg_read2(r2_s), .i_bank_read_data1(rd1_s), .i_bank_read_data2(rd2_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External register bank behaviour
  always @(posedge clk) begin
    if (pl_en) begin
      bank_z[pl_idx] <= pl_val;
      bank_s[pl_idx] <= pl_val;
    end
    if (en_z) begin
      wr_cnt_z <= wr_cnt_z + 1;
      if (sz_z) bank_z[rw_z] <= wd_z;
      else if (hl_z) bank_z[rw_z][15:8] <= wd_z[7:0];
      else bank_z[rw_z][7:0] <= wd_z[7:0];
    end
    if (en_s) begin
      wr_cnt_s <= wr_cnt_s + 1;
      if (sz_s) bank_s[rw_s] <= wd_s;
      else if (hl_s) bank_s[rw_s][15:8] <= wd_s[7:0];
      else bank_s[rw_s][7:0] <= wd_s[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int m_idx(input bit w, input bit [2:0] f);
    return w ? WORD_IDX[f] : BYTE_IDX[f];
  endfunction

  function automatic bit m_hi(input bit w, input bit [2:0] f);
    return !w && f >= 3'd4;
  endfunction

  function automatic logic [15:0] m_read(input bit w, input bit [2:0] f, input bit sext);
    logic [15:0] v;
    logic [7:0]  b;
    v = exp_bank[m_idx(w, f)];
    if (w) return v;
    b = m_hi(w, f) ? v[15:8] : v[7:0];
    return sext ? 16'(signed'(b)) : 16'(b);
  endfunction

  task automatic m_write(input bit w, input bit [2:0] f, input logic [15:0] res);
    int i;
    i = m_idx(w, f);
    if (w) exp_bank[i] = res;
    else if (m_hi(w, f)) exp_bank[i][15:8] = res[7:0];
    else exp_bank[i][7:0] = res[7:0];
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    pl_en = 1'b1; pl_idx = 3'(idx); pl_val = val;
    exp_bank[idx] = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_bank_z"}, {16'(i), bank_z[i]}, {16'(i), exp_bank[i]});
      check({tag, "_bank_s"}, {16'(i), bank_s[i]}, {16'(i), exp_bank[i]});
    end
  endtask

  task automatic do_reset(input string tag, input int wc0);
    reset = 1'b1;
    #1;
    check({tag, "_rst_ready"}, {rq_z, rq_s}, 2'b11);
    check({tag, "_rst_flags"}, {ov_z, rr_z, dn_z, en_z, ov_s, rr_s, dn_s, en_s}, 8'h00);
    check({tag, "_rst_ops"}, {a_z, b_s}, 32'h0);
    check({tag, "_rst_bankout"}, {r1_z, r2_z, rw_z, wd_z, sz_z, hl_z}, 27'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_nowrite"}, wr_cnt_z + wr_cnt_s, wc0);
    check({tag, "_rst_idle"}, {rq_z, en_z, rq_s, en_s}, 4'b1010);
    check_bank(tag);
  endtask

  // Starts and ends at a falling edge with both controllers idle
  task automatic do_op(input string tag, input bit w, input bit [2:0] dst, input bit [2:0] src,
                       input bit wb, input logic [15:0] res, input int op_stall,
                       input int res_stall, input int abort);
    logic [15:0] ea_z, eb_z, ea_s, eb_s, ewd;
    int wc0;
    wc0 = wr_cnt_z + wr_cnt_s;
    check({tag, "_idle_ready"}, {rq_z, rq_s}, 2'b11);
    req_valid = 1'b1; req_w = w; req_dst = dst; req_src = src; req_wb = wb;
    ea_z = m_read(w, dst, 1'b0); eb_z = m_read(w, src, 1'b0);
    ea_s = m_read(w, dst, 1'b1); eb_s = m_read(w, src, 1'b1);
    @(negedge clk);
    check({tag, "_read_busy"}, {rq_z, ov_z, dn_z, rq_s, ov_s, dn_s}, 6'b0);
    req_valid = 1'b1; req_w = 1'($urandom); req_wb = 1'($urandom);
    req_dst = 3'($urandom); req_src = 3'($urandom);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_oper_valid"}, {ov_z, ov_s, rq_z, rq_s}, 4'b1100);
    check({tag, "_op_z"}, {a_z, b_z}, {ea_z, eb_z});
    check({tag, "_op_s"}, {a_s, b_s}, {ea_s, eb_s});
    if (abort == 1) begin
      do_reset({tag, "_oper"}, wc0);
      return;
    end
    op_ready = 1'b0;
    for (int i = 0; i < op_stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_op"}, {ov_z, ov_s, a_z, b_z, a_s, b_s},
            {2'b11, ea_z, eb_z, ea_s, eb_s});
    end
    op_ready = 1'b1;
    @(negedge clk);
    op_ready = 1'b0;
    check({tag, "_result"}, {rr_z, rr_s, ov_z, ov_s}, 4'b1100);
    for (int i = 0; i < res_stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_res"}, {rr_z, rr_s, dn_z, dn_s}, 4'b1100);
    end
    res_valid = 1'b1; res_data = res;
    #1;
    check({tag, "_res_done"}, {dn_z, dn_s, en_z, en_s}, {~wb, ~wb, 2'b00});
    @(negedge clk);
    res_valid = 1'b0; res_data = 16'($urandom);
    if (wb) begin
      ewd = w ? res : {8'h00, res[7:0]};
      check({tag, "_wr_z"}, {en_z, dn_z, rw_z, sz_z, hl_z, wd_z},
            {2'b11, 3'(m_idx(w, dst)), w, m_hi(w, dst), ewd});
      check({tag, "_wr_s"}, {en_s, dn_s, rw_s, sz_s, hl_s, wd_s},
            {2'b11, 3'(m_idx(w, dst)), w, m_hi(w, dst), ewd});
      if (abort == 2) begin
        do_reset({tag, "_write"}, wc0);
        return;
      end
      m_write(w, dst, res);
      @(negedge clk);
    end
    check({tag, "_end_idle"}, {rq_z, rq_s, en_z, en_s, dn_z, dn_s}, 6'b110000);
    check({tag, "_wr_count"}, wr_cnt_z + wr_cnt_s, wc0 + (wb ? 2 : 0));
    check_bank(tag);
  endtask

  initial begin
    WORD_IDX = '{0, 2, 3, 1, 4, 5, 6, 7};
    BYTE_IDX = '{0, 2, 3, 1, 0, 2, 3, 1};
    n_tests = 0; n_fail = 0;
    wr_cnt_z = 0; wr_cnt_s = 0;
    reset = 1'b1; req_valid = 1'b0; req_w = 1'b0; req_wb = 1'b0;
    req_dst = 3'd0; req_src = 3'd0; op_ready = 1'b0; res_valid = 1'b0;
    res_data = 16'h0; pl_en = 1'b0; pl_idx = 3'd0; pl_val = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_ready", {rq_z, rq_s}, 2'b11);
    check("reset_flags", {ov_z, rr_z, dn_z, en_z, ov_s, rr_s, dn_s, en_s}, 8'h00);
    check("reset_ops", {a_z, b_z, a_s, b_s}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) preload(i, 16'h0000);

    preload(0, 16'h1234); preload(2, 16'h00FF);
    do_op("t1_word_add", 1'b1, 3'b000, 3'b001, 1'b1, 16'h1333, 0, 0, 0);
    preload(1, 16'hA5C3);
    do_op("t2_bh_bl", 1'b0, 3'b111, 3'b011, 1'b1, 16'h0068, 0, 0, 0);
    preload(3, 16'h8001);
    do_op("t3_dh", 1'b0, 3'b000, 3'b110, 1'b0, 16'h0000, 0, 0, 0);
    do_op("t3_dl", 1'b0, 3'b000, 3'b010, 1'b0, 16'h0000, 0, 0, 0);
    do_op("t4_cmp_stall", 1'b1, 3'b011, 3'b010, 1'b0, 16'hFFFF, 3, 2, 0);
    preload(4, 16'h5555);
    do_op("t5_rst_oper", 1'b1, 3'b100, 3'b000, 1'b1, 16'hDEAD, 0, 0, 1);
    do_op("t5_rst_write", 1'b1, 3'b100, 3'b000, 1'b1, 16'hDEAD, 0, 0, 2);
    do_op("t6_wr_si", 1'b1, 3'b110, 3'b110, 1'b1, 16'hBEEF, 0, 0, 0);
    do_op("t6_rd_si", 1'b1, 3'b000, 3'b110, 1'b0, 16'h0000, 0, 0, 0);

    for (int i = 0; i < 8; i++) preload(i, 16'($urandom));
    for (int n = 0; n < 40; n++) begin
      do_op("rand", 1'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
            16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
